branch_resolve_queue: RTL and testbench

- Resolution-side partner of the 2-bit saturating counter tables.
- Holds in-flight predictions in fetch order, pairs each with its actual branch outcome at resolve time, and drives the counter update stream (index + outcome).
- Detects mispredicts, squashes wrong-path entries, and keeps a saturating mispredict count.
- Sits between the fetch/predict stage and the PHT/choice-table update ports.

---
 rtl/branch_resolve_queue.sv | 118 +++++++++++
 tb/tb_branch_resolve_queue.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_queue.sv
// Branch resolve queue: in-flight predictions in fetch order, paired with
// resolved outcomes to drive counter-table updates and mispredict squash.
//
// Ports:
//   clock, reset_n            clock, async active-low reset
//   pred_valid/ready/idx/taken  prediction push from fetch (ready = !full)
//   res_valid, res_taken      resolution of the oldest in-flight branch
//   flush                     discard all entries, ignore same-cycle traffic
//   upd_valid/idx/taken       registered counter-table update strobe
//   mispredict, res_error     registered one-cycle event pulses
//   occupancy, miss_count     entry count, saturating mispredict total
module branch_resolve_queue #(
    parameter int DEPTH = 8,
    parameter int IDX_W = 10,
    parameter int CNT_W = 16
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       pred_valid,
    output logic                       pred_ready,
    input  logic [IDX_W-1:0]           pred_idx,
    input  logic                       pred_taken,
    input  logic                       res_valid,
    input  logic                       res_taken,
    input  logic                       flush,
    output logic                       upd_valid,
    output logic [IDX_W-1:0]           upd_idx,
    output logic                       upd_taken,
    output logic                       mispredict,
    output logic                       res_error,
    output logic [$clog2(DEPTH+1)-1:0] occupancy,
    output logic [CNT_W-1:0]           miss_count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OW = $clog2(DEPTH+1);

    logic [IDX_W-1:0] mem_idx [DEPTH];
    logic             mem_tk  [DEPTH];

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [OW-1:0] occ;

    logic full;
    logic empty;
    logic do_pop;
    logic miss;
    logic do_push;
    logic squash;

    assign full  = (occ == OW'(DEPTH));
    assign empty = (occ == '0);

    // Readiness comes from registered occupancy only; a pop in the
    // same cycle does not free a slot for a push.
    assign pred_ready = !full;

    assign do_pop  = res_valid && !empty && !flush;
    assign miss    = do_pop && (mem_tk[head] != res_taken);
    // A push alongside a mispredict is on the wrong path and is dropped.
    assign do_push = pred_valid && !full && !flush && !miss;
    assign squash  = flush || miss;

    assign occupancy = occ;

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem_idx[tail] <= pred_idx;
            mem_tk[tail]  <= pred_taken;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else if (squash) begin
            // Empty the queue by collapsing head onto tail.
            head <= tail;
            occ  <= '0;
        end else begin
            if (do_pop)
                head <= head + PW'(1);
            if (do_push)
                tail <= tail + PW'(1);
            if (do_push && !do_pop)
                occ <= occ + OW'(1);
            else if (do_pop && !do_push)
                occ <= occ - OW'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            upd_valid  <= 1'b0;
            upd_idx    <= '0;
            upd_taken  <= 1'b0;
            mispredict <= 1'b0;
            res_error  <= 1'b0;
        end else begin
            upd_valid  <= do_pop;
            upd_idx    <= do_pop ? mem_idx[head] : '0;
            upd_taken  <= do_pop && res_taken;
            mispredict <= miss;
            res_error  <= res_valid && empty && !flush;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)
            miss_count <= '0;
        else if (miss && (miss_count != '1))
            miss_count <= miss_count + CNT_W'(1);
    end

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Bench for branch_resolve_queue: directed vector table, hand sequences,
// and random traffic against a queue-based reference model.
module tb_branch_resolve_queue;

    localparam int DEPTH = 8;

    logic       clock;
    logic       reset_n;
    logic       pred_valid;
    logic       pred_ready;
    logic [9:0] pred_idx;
    logic       pred_taken;
    logic       res_valid;
    logic       res_taken;
    logic       flush;
    logic       upd_valid;
    logic [9:0] upd_idx;
    logic       upd_taken;
    logic       mispredict;
    logic       res_error;
    logic [3:0] occupancy;
    logic [15:0] miss_count;

    // Narrow-counter instance sharing the stimulus, used to reach saturation.
    logic       s_ready;
    logic       s_uv;
    logic [9:0] s_uidx;
    logic       s_ut;
    logic       s_mp;
    logic       s_err;
    logic [3:0] s_occ;
    logic [1:0] s_mc;

    int total = 0;
    int bad = 0;

    branch_resolve_queue #(.DEPTH(DEPTH), .IDX_W(10), .CNT_W(16)) dut (
        .clock(clock), .reset_n(reset_n),
        .pred_valid(pred_valid), .pred_ready(pred_ready),
        .pred_idx(pred_idx), .pred_taken(pred_taken),
        .res_valid(res_valid), .res_taken(res_taken), .flush(flush),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
        .mispredict(mispredict), .res_error(res_error),
        .occupancy(occupancy), .miss_count(miss_count)
    );

    branch_resolve_queue #(.DEPTH(DEPTH), .IDX_W(10), .CNT_W(2)) dut_s (
        .clock(clock), .reset_n(reset_n),
        .pred_valid(pred_valid), .pred_ready(s_ready),
        .pred_idx(pred_idx), .pred_taken(pred_taken),
        .res_valid(res_valid), .res_taken(res_taken), .flush(flush),
        .upd_valid(s_uv), .upd_idx(s_uidx), .upd_taken(s_ut),
        .mispredict(s_mp), .res_error(s_err),
        .occupancy(s_occ), .miss_count(s_mc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [9:0] idx;
        logic       t;
    } ent_t;

    typedef struct {
        logic       pv;
        logic [9:0] pidx;
        logic       pt;
        logic       rv;
        logic       rt;
        logic       fl;
        logic       uv;
        logic [9:0] uidx;
        logic       ut;
        logic       mp;
        logic       er;
        int         occ;
        logic       rdy;
    } vec_t;

    ent_t mq[$];
    int   misses;
    vec_t vecs[$];

    logic       e_uv;
    logic [9:0] e_uidx;
    logic       e_ut;
    logic       e_mp;
    logic       e_er;

    function void chk(input string n, input logic [31:0] a,
                      input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", n, a, e);
        end
    endfunction

    function void add(input logic pv, input logic [9:0] pidx,
                      input logic pt, input logic rv, input logic rt,
                      input logic fl, input logic uv,
                      input logic [9:0] uidx, input logic ut,
                      input logic mp, input logic er, input int occ,
                      input logic rdy);
        vec_t v;
        v.pv = pv; v.pidx = pidx; v.pt = pt;
        v.rv = rv; v.rt = rt; v.fl = fl;
        v.uv = uv; v.uidx = uidx; v.ut = ut;
        v.mp = mp; v.er = er; v.occ = occ; v.rdy = rdy;
        vecs.push_back(v);
    endfunction

    function int sat(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Apply one cycle of stimulus, advance the model, compare after edge.
    task automatic cyc(input logic pv, input logic [9:0] pidx,
                       input logic pt, input logic rv, input logic rt,
                       input logic fl);
        ent_t e;
        bit rdy;
        pred_valid = pv; pred_idx = pidx; pred_taken = pt;
        res_valid = rv; res_taken = rt; flush = fl;
        e_uv = 0; e_uidx = '0; e_ut = 0; e_mp = 0; e_er = 0;
        rdy = mq.size() < DEPTH;
        if (fl) begin
            mq.delete();
        end else begin
            if (rv && mq.size() > 0) begin
                e = mq.pop_front();
                e_uv = 1; e_uidx = e.idx; e_ut = rt;
                e_mp = (e.t != rt);
            end else if (rv) begin
                e_er = 1;
            end
            if (e_mp) begin
                mq.delete();
                misses++;
            end else if (pv && rdy) begin
                e.idx = pidx; e.t = pt;
                mq.push_back(e);
            end
        end
        @(posedge clock);
        #1;
        chk("m_upd_valid", 32'(upd_valid), 32'(e_uv));
        chk("m_upd_idx", 32'(upd_idx), 32'(e_uidx));
        chk("m_upd_taken", 32'(upd_taken), 32'(e_ut));
        chk("m_mispredict", 32'(mispredict), 32'(e_mp));
        chk("m_res_error", 32'(res_error), 32'(e_er));
        chk("m_occupancy", 32'(occupancy), 32'(mq.size()));
        chk("m_pred_ready", 32'(pred_ready), 32'(mq.size() < DEPTH));
        chk("m_miss_count", 32'(miss_count), 32'(sat(misses, 65535)));
        chk("m_miss_sat", 32'(s_mc), 32'(sat(misses, 3)));
    endtask

    initial begin
        logic pv, pt, rv, rt, fl;
        logic [9:0] ix;
        string nm;

        // pv pidx pt rv rt fl | uv uidx ut mp er occ rdy
        add(1, 10'h005, 1, 0, 0, 0, 0, 10'h000, 0, 0, 0, 1, 1);
        add(1, 10'h006, 0, 0, 0, 0, 0, 10'h000, 0, 0, 0, 2, 1);
        add(1, 10'h007, 1, 0, 0, 0, 0, 10'h000, 0, 0, 0, 3, 1);
        add(0, 10'h000, 0, 1, 1, 0, 1, 10'h005, 1, 0, 0, 2, 1);
        add(0, 10'h000, 0, 1, 0, 0, 1, 10'h006, 0, 0, 0, 1, 1);
        add(0, 10'h000, 0, 1, 1, 0, 1, 10'h007, 1, 0, 0, 0, 1);
        add(1, 10'h010, 1, 0, 0, 0, 0, 10'h000, 0, 0, 0, 1, 1);
        add(1, 10'h011, 1, 0, 0, 0, 0, 10'h000, 0, 0, 0, 2, 1);
        add(1, 10'h012, 0, 0, 0, 0, 0, 10'h000, 0, 0, 0, 3, 1);
        add(0, 10'h000, 0, 1, 0, 0, 1, 10'h010, 0, 1, 0, 0, 1);
        add(0, 10'h000, 0, 0, 0, 0, 0, 10'h000, 0, 0, 0, 0, 1);
        add(1, 10'h020, 0, 1, 0, 0, 0, 10'h000, 0, 0, 1, 1, 1);
        add(0, 10'h000, 0, 0, 0, 0, 0, 10'h000, 0, 0, 0, 1, 1);
        add(1, 10'h030, 1, 0, 0, 0, 0, 10'h000, 0, 0, 0, 2, 1);
        add(1, 10'h031, 1, 0, 0, 0, 0, 10'h000, 0, 0, 0, 3, 1);
        add(1, 10'h032, 1, 1, 1, 1, 0, 10'h000, 0, 0, 0, 0, 1);
        add(0, 10'h000, 0, 1, 1, 0, 0, 10'h000, 0, 0, 1, 0, 1);
        for (int i = 0; i < 8; i++)
            add(1, 10'(10'h040 + i), 1, 0, 0, 0,
                0, 10'h000, 0, 0, 0, i + 1, (i < 7));
        add(1, 10'h048, 1, 1, 1, 0, 1, 10'h040, 1, 0, 0, 7, 1);
        add(0, 10'h000, 0, 0, 0, 0, 0, 10'h000, 0, 0, 0, 7, 1);
        for (int i = 0; i < 7; i++)
            add(0, 10'h000, 0, 1, 1, 0,
                1, 10'(10'h041 + i), 1, 0, 0, 6 - i, 1);

        misses = 0;
        reset_n = 0;
        pred_valid = 0; pred_idx = '0; pred_taken = 0;
        res_valid = 0; res_taken = 0; flush = 0;
        #12;
        chk("rst_occ", 32'(occupancy), 32'd0);
        chk("rst_ready", 32'(pred_ready), 32'd1);
        chk("rst_upd_valid", 32'(upd_valid), 32'd0);
        chk("rst_res_error", 32'(res_error), 32'd0);
        chk("rst_miss_count", 32'(miss_count), 32'd0);
        reset_n = 1;
        @(posedge clock);
        #1;

        foreach (vecs[i]) begin
            cyc(vecs[i].pv, vecs[i].pidx, vecs[i].pt,
                vecs[i].rv, vecs[i].rt, vecs[i].fl);
            nm = $sformatf("v%0d", i);
            chk({nm, "_uv"}, 32'(upd_valid), 32'(vecs[i].uv));
            chk({nm, "_uidx"}, 32'(upd_idx), 32'(vecs[i].uidx));
            chk({nm, "_ut"}, 32'(upd_taken), 32'(vecs[i].ut));
            chk({nm, "_mp"}, 32'(mispredict), 32'(vecs[i].mp));
            chk({nm, "_er"}, 32'(res_error), 32'(vecs[i].er));
            chk({nm, "_occ"}, 32'(occupancy), 32'(vecs[i].occ));
            chk({nm, "_rdy"}, 32'(pred_ready), 32'(vecs[i].rdy));
        end

        // Pointer wrap: 20 same-cycle push/pop pairs, occupancy held at 1.
        cyc(1, 10'h100, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            cyc(1, 10'(10'h101 + i), 1, 1, 1, 0);
            chk("wrap_idx", 32'(upd_idx), 32'(10'h100 + i));
            chk("wrap_occ", 32'(occupancy), 32'd1);
        end
        cyc(0, 10'h000, 0, 1, 1, 0);

        // Random traffic, first biased toward filling, then balanced.
        for (int i = 0; i < 3000; i++) begin
            if (i < 1000) begin
                pv = ($urandom_range(0, 9) < 8);
                rv = ($urandom_range(0, 9) < 3);
            end else begin
                pv = ($urandom_range(0, 9) < 6);
                rv = ($urandom_range(0, 9) < 5);
            end
            fl = ($urandom_range(0, 49) == 0);
            pt = 1'($urandom_range(0, 1));
            ix = 10'($urandom_range(0, 1023));
            if (mq.size() > 0 && $urandom_range(0, 9) < 8)
                rt = mq[0].t;
            else
                rt = 1'($urandom_range(0, 1));
            cyc(pv, ix, pt, rv, rt, fl);
        end

        // Reset mid-stream clears outputs without a clock edge.
        cyc(1, 10'h200, 1, 0, 0, 0);
        cyc(1, 10'h201, 0, 0, 0, 0);
        cyc(1, 10'h202, 1, 1, 0, 0);
        #2;
        reset_n = 0;
        #1;
        mq.delete();
        misses = 0;
        chk("async_upd_valid", 32'(upd_valid), 32'd0);
        chk("async_mispredict", 32'(mispredict), 32'd0);
        chk("async_occ", 32'(occupancy), 32'd0);
        chk("async_ready", 32'(pred_ready), 32'd1);
        chk("async_miss_count", 32'(miss_count), 32'd0);
        #1;
        reset_n = 1;
        cyc(1, 10'h300, 1, 0, 0, 0);
        cyc(0, 10'h000, 0, 1, 1, 0);
        cyc(0, 10'h000, 0, 0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
